fir_decim_quant: RTL and testbench

- Output stage placed directly downstream of FirFilter.
- Consumes the full-width valid-qualified filter output and keeps every DECIM-th valid sample.
- Drops FRAC_DROP LSBs using a selectable rounding mode, then saturates to OUTPUT_WIDTH.
- Keeps overflow statistics for software.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_round_sat.sv | 58 +++++
 rtl/fir_decim_quant.sv | 111 +++++++++++
 tb/tb_fir_decim_quant.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR output-path types and helpers
package fir_pkg;

    typedef enum logic [1:0] {
        ROUND_TRUNC      = 2'd0,
        ROUND_HALF_UP    = 2'd1,
        ROUND_CONVERGENT = 2'd2
    } round_mode_e;

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                        input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - combinational round (with guard bit) and saturate core
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int IN_W       = 26,
    parameter int OUT_W      = 16,
    parameter int FRAC_DROP  = 8,
    parameter int ROUND_MODE = 1
) (
    input  logic [IN_W-1:0]           din_i,
    output logic [IN_W-FRAC_DROP:0]   rnd_o,
    input  logic [IN_W-FRAC_DROP:0]   r_i,
    output logic [OUT_W-1:0]          sat_o,
    output logic                      sat_hit_o
);

    localparam int RW = IN_W - FRAC_DROP + 1;

    generate
        if (FRAC_DROP == 0) begin : g_ident
            assign rnd_o = {din_i[IN_W-1], din_i};
        end else begin : g_round
            logic [RW-1:0] trunc;
            logic          half;
            logic          below;
            logic          inc;

            assign trunc = {din_i[IN_W-1], din_i[IN_W-1:FRAC_DROP]};
            assign half  = din_i[FRAC_DROP-1];

            if (FRAC_DROP > 1) begin : g_below
                assign below = |din_i[FRAC_DROP-2:0];
            end else begin : g_nobelow
                assign below = 1'b0;
            end

            // Convergent only differs on an exact half: bump when odd so the result ends even.
            always_comb begin
                case (ROUND_MODE)
                    int'(ROUND_HALF_UP):    inc = half;
                    int'(ROUND_CONVERGENT): inc = half & (below | trunc[0]);
                    default:                inc = 1'b0;
                endcase
            end

            assign rnd_o = trunc + RW'(inc);
        end
    endgenerate

    logic signed [63:0] r_ext;
    logic signed [63:0] r_sat;

    assign r_ext     = 64'($signed(r_i));
    assign r_sat     = sat_to_width(r_ext, OUT_W);
    assign sat_o     = r_sat[OUT_W-1:0];
    assign sat_hit_o = (r_sat != r_ext);

endmodule

// File: rtl/fir_decim_quant.sv
// rtl/fir_decim_quant.sv - decimate FIR output, round/saturate, keep overflow stats
module fir_decim_quant
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH   = 26,
    parameter int OUTPUT_WIDTH  = 16,
    parameter int FRAC_DROP     = 8,
    parameter int DECIM         = 4,
    parameter int PHASE         = 0,
    parameter int ROUND_MODE    = 1,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [INPUT_WIDTH-1:0]   din,
    input  logic                     decim_sync,
    input  logic                     clr_stats,
    output logic                     valid_out,
    output logic [OUTPUT_WIDTH-1:0]  dout,
    output logic                     sat_flag,
    output logic [SAT_CNT_WIDTH-1:0] sat_cnt
);

    localparam int RW = INPUT_WIDTH - FRAC_DROP + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    generate
        if (DECIM < 1 || PHASE < 0 || PHASE >= DECIM || INPUT_WIDTH - FRAC_DROP < OUTPUT_WIDTH) begin : g_bad_cfg
            $error("fir_decim_quant: invalid DECIM/PHASE/width configuration");
        end
    endgenerate

    logic [PW-1:0]            phase_q, phase_d;
    logic [PW-1:0]            idx;
    logic                     keep;
    logic                     v1_q;
    logic [RW-1:0]            r_q;
    logic                     v2_q;
    logic [OUTPUT_WIDTH-1:0]  dout_q;
    logic                     sat_flag_q, sat_flag_d;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;
    logic [RW-1:0]            rnd;
    logic [OUTPUT_WIDTH-1:0]  sat_val;
    logic                     sat_hit;

    // decim_sync re-labels the current sample as index 0 of a fresh group.
    always_comb begin
        idx     = decim_sync ? '0 : phase_q;
        keep    = valid_in && (idx == PW'(PHASE));
        phase_d = phase_q;
        if (valid_in) begin
            phase_d = (idx == PW'(DECIM - 1)) ? '0 : idx + PW'(1);
        end
    end

    fir_round_sat #(
        .IN_W       (INPUT_WIDTH),
        .OUT_W      (OUTPUT_WIDTH),
        .FRAC_DROP  (FRAC_DROP),
        .ROUND_MODE (ROUND_MODE)
    ) u_round_sat (
        .din_i     (din),
        .rnd_o     (rnd),
        .r_i       (r_q),
        .sat_o     (sat_val),
        .sat_hit_o (sat_hit)
    );

    // Clear applies first so a coincident saturation still registers as one event.
    always_comb begin
        sat_flag_d = clr_stats ? 1'b0 : sat_flag_q;
        sat_cnt_d  = clr_stats ? '0 : sat_cnt_q;
        if (v1_q && sat_hit) begin
            sat_flag_d = 1'b1;
            if (sat_cnt_d != '1) begin
                sat_cnt_d = sat_cnt_d + SAT_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= '0;
            v1_q       <= 1'b0;
            r_q        <= '0;
            v2_q       <= 1'b0;
            dout_q     <= '0;
            sat_flag_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            phase_q    <= phase_d;
            v1_q       <= keep;
            if (keep) begin
                r_q <= rnd;
            end
            v2_q       <= v1_q;
            if (v1_q) begin
                dout_q <= sat_val;
            end
            sat_flag_q <= sat_flag_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign valid_out = v2_q;
    assign dout      = dout_q;
    assign sat_flag  = sat_flag_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_fir_decim_quant.sv
// tb/tb_fir_decim_quant.sv - scoreboard bench over several fir_decim_quant configurations
`timescale 1ns/1ps
module tb_fir_decim_quant;

    localparam int NI = 6;

    function automatic int cfg_mode(input int g);
        return (g == 0) ? 0 : ((g == 2) ? 2 : 1);
    endfunction
    function automatic int cfg_decim(input int g);
        return (g == 3 || g == 4) ? 4 : 1;
    endfunction
    function automatic int cfg_phase(input int g);
        return (g == 3) ? 1 : 0;
    endfunction
    function automatic int cfg_cw(input int g);
        return (g == 5) ? 2 : 16;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [25:0] din = '0;
    logic        decim_sync = 1'b0;
    logic        clr_stats = 1'b0;

    logic        vout_w  [NI];
    logic [15:0] dout_w  [NI];
    logic        flag_w  [NI];
    logic [15:0] cnt_w   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CW = cfg_cw(g);
        logic [CW-1:0] cnt;
        fir_decim_quant #(
            .INPUT_WIDTH   (26),
            .OUTPUT_WIDTH  (16),
            .FRAC_DROP     (8),
            .DECIM         (cfg_decim(g)),
            .PHASE         (cfg_phase(g)),
            .ROUND_MODE    (cfg_mode(g)),
            .SAT_CNT_WIDTH (CW)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .valid_in   (valid_in),
            .din        (din),
            .decim_sync (decim_sync),
            .clr_stats  (clr_stats),
            .valid_out  (vout_w[g]),
            .dout       (dout_w[g]),
            .sat_flag   (flag_w[g]),
            .sat_cnt    (cnt)
        );
        assign cnt_w[g] = 16'(cnt);
    end

    typedef struct packed {
        int          stamp;
        logic [15:0] val;
    } exp_t;

    exp_t        expq       [NI][$];
    int          sat_stamps [NI][$];
    int          idx_m      [NI];
    logic        exp_flag   [NI];
    int          exp_cnt    [NI];
    logic [15:0] last_dout  [NI];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;
    exp_t        e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint floor_div(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    // Quantise x / 256 by the rounding rule, before clamping.
    function automatic longint ref_round(input longint x, input int mode);
        longint q;
        longint rem;
        q   = floor_div(x, 256);
        rem = x - q * 256;
        if (mode == 1) return (2 * rem >= 256) ? q + 1 : q;
        if (mode == 2) begin
            if (2 * rem > 256) return q + 1;
            if (2 * rem == 256) return (q % 2 != 0) ? q + 1 : q;
        end
        return q;
    endfunction

    task automatic model_clear();
        for (int g = 0; g < NI; g++) begin
            expq[g].delete();
            sat_stamps[g].delete();
            idx_m[g]    = 0;
            exp_flag[g] = 1'b0;
            exp_cnt[g]  = 0;
        end
    endtask

    task automatic drive(input logic v, input logic [25:0] d, input logic s, input logic c);
        longint x;
        longint r;
        longint cl;
        int     k;
        @(negedge clk);
        valid_in   = v;
        din        = d;
        decim_sync = s;
        clr_stats  = c;
        x = longint'($signed(d));
        for (int g = 0; g < NI; g++) begin
            if (c) begin
                exp_flag[g] = 1'b0;
                exp_cnt[g]  = 0;
            end
            while (sat_stamps[g].size() > 0 && sat_stamps[g][0] == cyc + 1) begin
                void'(sat_stamps[g].pop_front());
                exp_flag[g] = 1'b1;
                if (exp_cnt[g] < (1 << cfg_cw(g)) - 1) exp_cnt[g]++;
            end
            if (v) begin
                k = s ? 0 : idx_m[g];
                if (k == cfg_phase(g)) begin
                    r  = ref_round(x, cfg_mode(g));
                    cl = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
                    expq[g].push_back('{stamp: cyc + 2, val: 16'(cl)});
                    if (cl != r) sat_stamps[g].push_back(cyc + 2);
                end
                idx_m[g] = (k + 1) % cfg_decim(g);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Asserts reset mid-cycle, after the last driven sample's predecessor is already in stage 1.
    task automatic do_reset();
        #2;
        rst        = 1'b1;
        valid_in   = 1'b0;
        din        = '0;
        decim_sync = 1'b0;
        clr_stats  = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check(input string name, input int g, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", name, g, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                check("rst_valid", g, vout_w[g], 0);
                last_dout[g] = '0;
            end else if (vout_w[g]) begin
                if (expq[g].size() == 0) begin
                    check("spurious_valid", g, vout_w[g], 0);
                end else begin
                    e = expq[g].pop_front();
                    check("latency", g, cyc, e.stamp);
                    check("dout", g, dout_w[g], e.val);
                    last_dout[g] = e.val;
                end
            end else if (expq[g].size() != 0 && expq[g][0].stamp <= cyc) begin
                check("missing_valid", g, vout_w[g], 1);
                void'(expq[g].pop_front());
            end
            check("dout_hold", g, dout_w[g], last_dout[g]);
            check("sat_flag", g, flag_w[g], exp_flag[g]);
            check("sat_cnt", g, cnt_w[g], exp_cnt[g]);
        end
        if (done) begin
            for (int g = 0; g < NI; g++) check("drain", g, expq[g].size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        model_clear();
        for (int g = 0; g < NI; g++) last_dout[g] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // rounding: 1.5, 2.5, -1.5 in LSBs of the kept field
        drive(1'b1, 26'd384, 1'b0, 1'b0);
        drive(1'b1, 26'd640, 1'b0, 1'b0);
        drive(1'b1, 26'h3FFFE80, 1'b0, 1'b0);
        idle(4);

        // saturation both ways, clear, then clear coinciding with a saturation
        drive(1'b1, 26'h0800000, 1'b0, 1'b0);
        drive(1'b1, 26'h3000000, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 26'h0800000, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle(3);
        for (int i = 0; i < 5; i++) drive(1'b1, 26'h3000000, 1'b0, 1'b0);
        idle(4);

        // decimation, continuous
        do_reset();
        for (int k = 0; k < 12; k++) drive(1'b1, 26'(k << 8), 1'b0, 1'b0);
        idle(4);

        // decimation with random gaps
        do_reset();
        for (int k = 0; k < 12; k++) begin
            idle($urandom_range(0, 2));
            drive(1'b1, 26'(k << 8), 1'b0, 1'b0);
        end
        idle(4);

        // decim_sync on sample 6
        do_reset();
        for (int k = 0; k < 12; k++) drive(1'b1, 26'(k << 8), (k == 6), 1'b0);
        idle(4);

        // reset with samples in flight, then restart from index 0
        drive(1'b1, 26'd1000, 1'b0, 1'b0);
        drive(1'b1, 26'd2000, 1'b0, 1'b0);
        do_reset();
        idle(3);
        for (int k = 0; k < 6; k++) drive(1'b1, 26'((k + 20) << 8), 1'b0, 1'b0);
        idle(4);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            logic [25:0] d;
            d = ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'($signed(18'($urandom)));
            drive(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 19) == 0));
        end
        idle(5);
        done = 1'b1;
    end

endmodule
